// File: rtl/lcd_controller.sv
// Write-only HD44780 sequencer: runs the power-on init on its own, then writes one
// command/data byte per valid/ready handshake with counter-timed setup, E pulse, hold and wait.
module lcd_controller #(
    parameter int SETUP_CYCLES     = 2,
    parameter int PULSE_CYCLES     = 12,
    parameter int HOLD_CYCLES      = 2,
    parameter int CMD_WAIT_CYCLES  = 2000,
    parameter int SLOW_WAIT_CYCLES = 82000,
    parameter int POWERON_CYCLES   = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(SETUP_CYCLES, PULSE_CYCLES), max2(HOLD_CYCLES, CMD_WAIT_CYCLES)),
                                  max2(SLOW_WAIT_CYCLES, POWERON_CYCLES));
    // Counters run from duration-1 down to zero, so $clog2(MAX_CYC) bits suffice.
    localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        ST_POWERON,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       init_idx, idx_n;
    logic             rs_n, e_n, done_n, ready_n;
    logic [7:0]       data_n;

    logic cnt_zero, accept, slow_cmd, init_last;

    assign cnt_zero  = (cnt == '0);
    assign accept    = req_valid && req_ready;
    assign slow_cmd  = !lcd_rs && (lcd_data >= 8'h01) && (lcd_data <= 8'h03);
    assign init_last = (init_idx == 2'd3);
    assign lcd_rw    = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_POWERON;
            cnt       <= CNT_W'(POWERON_CYCLES - 1);
            init_idx  <= 2'd0;
            init_done <= 1'b0;
            req_ready <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            init_idx  <= idx_n;
            init_done <= done_n;
            req_ready <= ready_n;
            lcd_rs    <= rs_n;
            lcd_e     <= e_n;
            lcd_data  <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt_zero ? cnt : cnt - CNT_W'(1);
        idx_n   = init_idx;
        case (state)
            ST_POWERON: if (cnt_zero) begin
                state_n = ST_SETUP;
                cnt_n   = CNT_W'(SETUP_CYCLES - 1);
                idx_n   = 2'd0;
            end
            ST_IDLE: if (accept) begin
                state_n = ST_SETUP;
                cnt_n   = CNT_W'(SETUP_CYCLES - 1);
            end
            ST_SETUP: if (cnt_zero) begin
                state_n = ST_PULSE;
                cnt_n   = CNT_W'(PULSE_CYCLES - 1);
            end
            ST_PULSE: if (cnt_zero) begin
                state_n = ST_HOLD;
                cnt_n   = CNT_W'(HOLD_CYCLES - 1);
            end
            ST_HOLD: if (cnt_zero) begin
                state_n = ST_WAIT;
                cnt_n   = slow_cmd ? CNT_W'(SLOW_WAIT_CYCLES - 1) : CNT_W'(CMD_WAIT_CYCLES - 1);
            end
            ST_WAIT: if (cnt_zero) begin
                if (!init_done && !init_last) begin
                    state_n = ST_SETUP;
                    cnt_n   = CNT_W'(SETUP_CYCLES - 1);
                    idx_n   = init_idx + 2'd1;
                end else begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = ST_POWERON;
                cnt_n   = CNT_W'(POWERON_CYCLES - 1);
                idx_n   = 2'd0;
            end
        endcase
    end

    // Output values are computed here and registered alongside the state.
    always_comb begin
        rs_n    = lcd_rs;
        data_n  = lcd_data;
        done_n  = init_done;
        if (cnt_zero && (state == ST_POWERON || (state == ST_WAIT && !init_done && !init_last))) begin
            rs_n   = 1'b0;
            data_n = init_rom(idx_n);
        end else if (state == ST_IDLE && accept) begin
            rs_n   = req_rs;
            data_n = req_data;
        end
        if (state == ST_WAIT && cnt_zero && !init_done && init_last)
            done_n = 1'b1;
        e_n     = (state_n == ST_PULSE);
        ready_n = (state_n == ST_IDLE) && done_n;
    end

endmodule

// File: tb/tb_lcd_controller.sv
// Scoreboard bench for lcd_controller: expected LCD bytes are queued by the stimulus
// and a monitor checks each E strobe, plus handshake latencies and reset behaviour.
`timescale 1ns/1ps
module tb_lcd_controller;

    localparam int SETUP     = 2;
    localparam int PULSE     = 3;
    localparam int HOLD      = 1;
    localparam int CMD_WAIT  = 5;
    localparam int SLOW_WAIT = 20;
    localparam int POWERON   = 10;
    localparam int LIMIT     = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_controller #(
        .SETUP_CYCLES    (SETUP),
        .PULSE_CYCLES    (PULSE),
        .HOLD_CYCLES     (HOLD),
        .CMD_WAIT_CYCLES (CMD_WAIT),
        .SLOW_WAIT_CYCLES(SLOW_WAIT),
        .POWERON_CYCLES  (POWERON)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rs   (req_rs),
        .req_data (req_data),
        .init_done(init_done),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data)
    );

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: every rising E must carry the next queued byte, after the setup time.
    initial begin
        logic       prev_e = 1'b0;
        logic [8:0] prev_bus = 9'h0;
        logic [8:0] exp;
        int         since = 0;
        int         width = 0;
        forever begin
            @(negedge clk);
            if ({lcd_rs, lcd_data} != prev_bus) since = 0;
            else since++;
            prev_bus = {lcd_rs, lcd_data};
            if (lcd_e && !prev_e) begin
                width = 1;
                check("setup_cycles", since, SETUP);
                check("rw_low", lcd_rw, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected none", {lcd_rs, lcd_data});
                end else begin
                    exp = exp_q.pop_front();
                    check("lcd_byte", {lcd_rs, lcd_data}, exp);
                end
            end else if (lcd_e) begin
                width++;
            end else if (prev_e && !rst) begin
                check("e_width", width, PULSE);
            end
            prev_e = lcd_e;
        end
    end

    task automatic run_init();
        int   n;
        logic early;
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'hAA;
        rst       = 1'b0;
        n = 0;
        early = 1'b0;
        while (!init_done && n < LIMIT) begin
            @(negedge clk);
            n++;
            if (req_ready && !init_done) early = 1'b1;
        end
        req_valid = 1'b0;
        if (!init_done) fail_now("init_timeout");
        check("init_latency", n, 69);
        check("ready_with_done", req_ready, 1);
        check("no_early_ready", early, 0);
        check("init_bytes_seen", exp_q.size(), 0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!req_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_write(input logic rs, input logic [7:0] d, input int exp_lat);
        int n;
        exp_q.push_back({rs, d});
        wait_ready(n);
        if (!req_ready) begin
            fail_now("ready_timeout");
            void'(exp_q.pop_back());
            return;
        end
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        @(negedge clk);
        req_valid = 1'b0;
        check("accept_rs", lcd_rs, rs);
        check("accept_data", lcd_data, d);
        check("ready_drop", req_ready, 0);
        wait_ready(n);
        check("ready_latency", n, exp_lat);
    endtask

    initial begin
        int   n;
        int   ready_hi;
        logic stable;

        repeat (3) @(negedge clk);
        check("rst_lcd_e", lcd_e, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_lcd_data", lcd_data, 8'h00);
        check("rst_req_ready", req_ready, 0);
        check("rst_init_done", init_done, 0);

        run_init();

        do_write(1'b1, 8'h41, 11);
        do_write(1'b0, 8'h01, 26);
        do_write(1'b0, 8'h02, 26);
        do_write(1'b0, 8'h80, 11);
        do_write(1'b1, 8'h01, 11);
        do_write(1'b0, 8'h03, 26);

        // Back-to-back with req_valid held high; req_data churns while busy.
        exp_q.push_back({1'b1, 8'h48});
        exp_q.push_back({1'b1, 8'h49});
        wait_ready(n);
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h48;
        @(negedge clk);
        check("b2b_first_data", lcd_data, 8'h48);
        req_data = 8'h49;
        n = 0;
        ready_hi = 0;
        stable = 1'b1;
        while (n < LIMIT) begin
            @(negedge clk);
            n++;
            if (lcd_data == 8'h49) break;
            if (lcd_data != 8'h48) stable = 1'b0;
            if (req_ready) ready_hi++;
            if (n == 4) req_data = 8'h5A;
            if (n == 7) req_data = 8'h49;
        end
        req_valid = 1'b0;
        check("b2b_accept_interval", n, 12);
        check("b2b_ready_cycles", ready_hi, 1);
        check("b2b_data_stable", stable, 1);
        check("b2b_ready_drop", req_ready, 0);
        wait_ready(n);
        check("b2b_second_latency", n, 11);

        // Reset during the E pulse of a data write.
        exp_q.push_back({1'b1, 8'h33});
        wait_ready(n);
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h33;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!lcd_e && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("pulse_reached", lcd_e, 1);
        #2 rst = 1'b1;
        #1;
        check("async_e_drop", lcd_e, 0);
        check("async_done_clear", init_done, 0);
        check("async_ready_clear", req_ready, 0);
        check("async_data_clear", lcd_data, 8'h00);
        @(negedge clk);
        @(negedge clk);
        run_init();

        do_write(1'b1, 8'h42, 11);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
